// File: rtl/morse_pkg.sv
// Shared constants, state encoding and symbol-accumulator type for the morse receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package morse_pkg;

  // Symbol accumulator geometry: up to 6 symbols, length 0..6
  localparam int PAT_W = 6;
  localparam int LEN_W = 4;

  // Timing thresholds expressed in dot units
  localparam int DASH_UNITS     = 2;
  localparam int CHAR_GAP_UNITS = 2;
  localparam int WORD_GAP_UNITS = 5;
  localparam int SAT_UNITS      = 7;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MARK  = 3'd1,
    ST_SPACE = 3'd2,
    ST_EMIT  = 3'd3,
    ST_WORD  = 3'd4
  } state_t;

  // Pending character: first symbol in pat[0], dot = 1, dash = 0
  typedef struct packed {
    logic             ovf;
    logic [LEN_W-1:0] len;
    logic [PAT_W-1:0] pat;
  } sym_t;

endpackage

// File: rtl/morse_code_to_ascii.sv
// Combinational lookup from (pattern, length) to uppercase ASCII, with a hit flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: pat/len = accumulated symbols (pat[0] first, dot = 1); ascii = character on hit, 0 otherwise; hit = pattern known.
module morse_code_to_ascii
  import morse_pkg::*;
(
  input  logic [PAT_W-1:0] pat,
  input  logic [LEN_W-1:0] len,
  output logic [7:0]       ascii,
  output logic             hit
);

  // Patterns are written MSB-first, so the morse string reads right to left.
  always_comb begin
    ascii = 8'h00;
    hit   = 1'b1;
    case ({len, pat})
      {4'd2, 6'b000001}: ascii = "A";
      {4'd4, 6'b001110}: ascii = "B";
      {4'd4, 6'b001010}: ascii = "C";
      {4'd3, 6'b000110}: ascii = "D";
      {4'd1, 6'b000001}: ascii = "E";
      {4'd4, 6'b001011}: ascii = "F";
      {4'd3, 6'b000100}: ascii = "G";
      {4'd4, 6'b001111}: ascii = "H";
      {4'd2, 6'b000011}: ascii = "I";
      {4'd4, 6'b000001}: ascii = "J";
      {4'd3, 6'b000010}: ascii = "K";
      {4'd4, 6'b001101}: ascii = "L";
      {4'd2, 6'b000000}: ascii = "M";
      {4'd2, 6'b000010}: ascii = "N";
      {4'd3, 6'b000000}: ascii = "O";
      {4'd4, 6'b001001}: ascii = "P";
      {4'd4, 6'b000100}: ascii = "Q";
      {4'd3, 6'b000101}: ascii = "R";
      {4'd3, 6'b000111}: ascii = "S";
      {4'd1, 6'b000000}: ascii = "T";
      {4'd3, 6'b000011}: ascii = "U";
      {4'd4, 6'b000111}: ascii = "V";
      {4'd3, 6'b000001}: ascii = "W";
      {4'd4, 6'b000110}: ascii = "X";
      {4'd4, 6'b000010}: ascii = "Y";
      {4'd4, 6'b001100}: ascii = "Z";
      {4'd5, 6'b000000}: ascii = "0";
      {4'd5, 6'b000001}: ascii = "1";
      {4'd5, 6'b000011}: ascii = "2";
      {4'd5, 6'b000111}: ascii = "3";
      {4'd5, 6'b001111}: ascii = "4";
      {4'd5, 6'b011111}: ascii = "5";
      {4'd5, 6'b011110}: ascii = "6";
      {4'd5, 6'b011100}: ascii = "7";
      {4'd5, 6'b011000}: ascii = "8";
      {4'd5, 6'b010000}: ascii = "9";
      {4'd6, 6'b010101}: ascii = ".";
      {4'd6, 6'b001100}: ascii = ",";
      {4'd6, 6'b110011}: ascii = "?";
      {4'd6, 6'b100001}: ascii = 8'h27;  // apostrophe
      {4'd5, 6'b010110}: ascii = "/";
      {4'd5, 6'b010010}: ascii = "(";
      {4'd6, 6'b010010}: ascii = ")";
      {4'd6, 6'b111000}: ascii = ":";
      {4'd5, 6'b001110}: ascii = "=";
      {4'd5, 6'b010101}: ascii = "+";
      {4'd6, 6'b011110}: ascii = "-";
      {4'd6, 6'b101101}: ascii = 8'h22;  // double quote
      {4'd6, 6'b101001}: ascii = "@";
      default:           hit   = 1'b0;
    endcase
  end

endmodule

// File: rtl/morse_key_decoder.sv
// Decodes a single morse key level into ASCII characters plus one space per word gap.
// Latency: character pulse 2U+1 cycles after the last key_s fall; word space 5U+1 cycles after it.
// Backpressure: none; ascii_o/valid_o/err_o are single-cycle pulses that must be captured when seen.
// Ports: clk_i, rst_i (sync, active-high), key_i (raw key, 1 = mark), ascii_o, valid_o, err_o, busy_o.
module morse_key_decoder
  import morse_pkg::*;
#(
  parameter int CLKS_PER_UNIT = 1_000_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       key_i,
  output logic [7:0] ascii_o,
  output logic       valid_o,
  output logic       err_o,
  output logic       busy_o
);

  localparam int CNT_W = $clog2(SAT_UNITS * CLKS_PER_UNIT + 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SAT_UNITS * CLKS_PER_UNIT);
  localparam logic [CNT_W-1:0] DASH_CNT = CNT_W'(DASH_UNITS * CLKS_PER_UNIT);
  // SPACE leaves one count early because EMIT adds a cycle before the
  // registered pulse; both pulses then land threshold+1 cycles after the fall.
  localparam logic [CNT_W-1:0] CHAR_LAST = CNT_W'(CHAR_GAP_UNITS * CLKS_PER_UNIT - 1);
  localparam logic [CNT_W-1:0] WORD_CNT  = CNT_W'(WORD_GAP_UNITS * CLKS_PER_UNIT);

  logic             key_meta;
  logic             key_s;
  logic             key_d;
  logic             key_rise;
  logic             key_fall;
  logic [CNT_W-1:0] cnt;
  state_t           state;
  state_t           state_nxt;
  sym_t             sym;
  sym_t             sym_nxt;
  logic [7:0]       ascii_nxt;
  logic             valid_nxt;
  logic             err_nxt;
  logic [7:0]       lut_ascii;
  logic             lut_hit;

  assign key_rise = key_s & ~key_d;
  assign key_fall = ~key_s & key_d;
  assign busy_o   = (state == ST_MARK) || (state == ST_SPACE) || (state == ST_EMIT);

  morse_code_to_ascii u_lut (
    .pat   (sym.pat),
    .len   (sym.len),
    .ascii (lut_ascii),
    .hit   (lut_hit)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      key_meta <= 1'b0;
      key_s    <= 1'b0;
      key_d    <= 1'b0;
      cnt      <= '0;
      state    <= ST_IDLE;
      sym      <= '0;
      ascii_o  <= 8'h00;
      valid_o  <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      key_meta <= key_i;
      key_s    <= key_meta;
      key_d    <= key_s;
      // On an edge cycle cnt still holds the length of the level that just ended.
      if (key_rise || key_fall) begin
        cnt <= CNT_W'(1);
      end else if (cnt != CNT_SAT) begin
        cnt <= cnt + 1'b1;
      end
      state   <= state_nxt;
      sym     <= sym_nxt;
      ascii_o <= ascii_nxt;
      valid_o <= valid_nxt;
      err_o   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sym_nxt   = sym;
    ascii_nxt = 8'h00;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (key_rise) state_nxt = ST_MARK;
      end
      ST_MARK: begin
        if (key_fall) begin
          if (sym.len == LEN_W'(PAT_W)) begin
            sym_nxt.ovf = 1'b1;
          end else begin
            if (cnt < DASH_CNT) sym_nxt.pat = sym.pat | (PAT_W'(1) << sym.len);
            sym_nxt.len = sym.len + 1'b1;
          end
          state_nxt = ST_SPACE;
        end
      end
      ST_SPACE: begin
        if (key_rise) begin
          state_nxt = ST_MARK;
        end else if (cnt >= CHAR_LAST) begin
          state_nxt = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (lut_hit && !sym.ovf) begin
          ascii_nxt = lut_ascii;
          valid_nxt = 1'b1;
        end else begin
          ascii_nxt = ASCII_QMARK;
          err_nxt   = 1'b1;
        end
        sym_nxt   = '0;
        state_nxt = ST_WORD;
      end
      ST_WORD: begin
        // Level test: a rise that arrived during EMIT is picked up here.
        if (key_s) begin
          state_nxt = ST_MARK;
        end else if (cnt >= WORD_CNT) begin
          ascii_nxt = ASCII_SPACE;
          valid_nxt = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_morse_key_decoder.sv
module tb_morse_key_decoder;

  localparam int U         = 4;
  localparam int SYNC      = 2;
  localparam int CHAR_DLY  = SYNC + 2 * U + 1;
  localparam int WORD_DLY  = SYNC + 5 * U + 1;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       key_i;
  logic [7:0] ascii_o;
  logic       valid_o;
  logic       err_o;
  logic       busy_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    logic [7:0] ch;
    logic       v;
    logic       e;
  } ev_t;

  ev_t evq[$];

  morse_key_decoder #(.CLKS_PER_UNIT(U)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .key_i   (key_i),
    .ascii_o (ascii_o),
    .valid_o (valid_o),
    .err_o   (err_o),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output pulse with its cycle stamp; valid and err must never coincide.
  always @(negedge clk) begin : mon
    ev_t ev;
    if (valid_o || err_o) begin
      ev.cyc = cyc;
      ev.ch  = ascii_o;
      ev.v   = valid_o;
      ev.e   = err_o;
      evq.push_back(ev);
      total++;
      assert (!(valid_o && err_o)) else begin
        bad++;
        $error("FAIL valid_err_overlap: got valid=%0b err=%0b at cyc %0d, expected not both", valid_o, err_o, cyc);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_ev(input string tag, input int idx, input int exp_cyc,
                        input logic [7:0] exp_ch, input logic exp_err);
    total++;
    assert (idx < evq.size()) else begin
      bad++;
      $error("FAIL %s: pulse %0d missing, got %0d pulses expected more", tag, idx, evq.size());
    end
    if (idx < evq.size()) begin
      chk({tag, ".cyc"},   evq[idx].cyc, exp_cyc);
      chk({tag, ".ascii"}, {24'h0, evq[idx].ch}, {24'h0, exp_ch});
      chk({tag, ".valid"}, {31'h0, evq[idx].v}, {31'h0, !exp_err});
      chk({tag, ".err"},   {31'h0, evq[idx].e}, {31'h0, exp_err});
    end
  endtask

  // Drive the key level and hold it for n clock edges; returns at posedge+1.
  task automatic hold(input logic lvl, input int n);
    key_i = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int f;
    int g;
    int h;

    // Reset
    rst_i = 1'b1;
    key_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ascii", {24'h0, ascii_o}, 32'h0);
    chk("rst.valid", {31'h0, valid_o}, 32'h0);
    chk("rst.err",   {31'h0, err_o},   32'h0);
    chk("rst.busy",  {31'h0, busy_o},  32'h0);
    rst_i = 1'b0;
    hold(1'b0, 5);
    chk("idle.busy", {31'h0, busy_o}, 32'h0);

    // "A": dot, dash, long gap -> 'A' then one space
    evq.delete();
    hold(1'b1, U);
    chk("A.busy_mark", {31'h0, busy_o}, 32'h1);
    hold(1'b0, U);
    hold(1'b1, 3 * U);
    f = cyc;
    hold(1'b0, 40);
    chk("A.count", evq.size(), 2);
    chk_ev("A.char", 0, f + CHAR_DLY, 8'h41, 1'b0);
    chk_ev("A.space", 1, f + WORD_DLY, 8'h20, 1'b0);
    chk("A.busy_end", {31'h0, busy_o}, 32'h0);

    // SOS with letter gaps of 3U: no space between letters
    evq.delete();
    hold(1'b1, U); hold(1'b0, U); hold(1'b1, U); hold(1'b0, U); hold(1'b1, U);
    f = cyc;
    hold(1'b0, 3 * U);
    hold(1'b1, 3 * U); hold(1'b0, U); hold(1'b1, 3 * U); hold(1'b0, U); hold(1'b1, 3 * U);
    g = cyc;
    hold(1'b0, 3 * U);
    hold(1'b1, U); hold(1'b0, U); hold(1'b1, U); hold(1'b0, U); hold(1'b1, U);
    h = cyc;
    hold(1'b0, 40);
    chk("SOS.count", evq.size(), 4);
    chk_ev("SOS.S1", 0, f + CHAR_DLY, 8'h53, 1'b0);
    chk_ev("SOS.O",  1, g + CHAR_DLY, 8'h4F, 1'b0);
    chk_ev("SOS.S2", 2, h + CHAR_DLY, 8'h53, 1'b0);
    chk_ev("SOS.sp", 3, h + WORD_DLY, 8'h20, 1'b0);

    // Seven dots (overflow) then unknown -.-.-. pattern
    evq.delete();
    f = 0;
    for (int i = 0; i < 7; i++) begin
      hold(1'b1, U);
      if (i == 6) f = cyc;
      hold(1'b0, (i == 6) ? 3 * U : U);
    end
    for (int i = 0; i < 6; i++) begin
      hold(1'b1, (i % 2 == 0) ? 2 * U : U);
      if (i == 5) g = cyc;
      if (i != 5) hold(1'b0, U);
    end
    hold(1'b0, 40);
    chk("ERR.count", evq.size(), 3);
    chk_ev("ERR.ovf",   0, f + CHAR_DLY, 8'h3F, 1'b1);
    chk_ev("ERR.unk",   1, g + CHAR_DLY, 8'h3F, 1'b1);
    chk_ev("ERR.space", 2, g + WORD_DLY, 8'h20, 1'b0);

    // Press-length boundary: 2U is a dash, 2U-1 is a dot
    evq.delete();
    hold(1'b1, 2 * U);
    f = cyc;
    hold(1'b0, 40);
    hold(1'b1, 2 * U - 1);
    g = cyc;
    hold(1'b0, 40);
    chk("LEN.count", evq.size(), 4);
    chk_ev("LEN.T",  0, f + CHAR_DLY, 8'h54, 1'b0);
    chk_ev("LEN.sp1", 1, f + WORD_DLY, 8'h20, 1'b0);
    chk_ev("LEN.E",  2, g + CHAR_DLY, 8'h45, 1'b0);
    chk_ev("LEN.sp2", 3, g + WORD_DLY, 8'h20, 1'b0);

    // Gap boundary: 2U ends the character (E E), 2U-1 does not (I)
    evq.delete();
    hold(1'b1, U);
    f = cyc;
    hold(1'b0, 2 * U);
    hold(1'b1, U);
    g = cyc;
    hold(1'b0, 40);
    hold(1'b1, U);
    hold(1'b0, 2 * U - 1);
    hold(1'b1, U);
    h = cyc;
    hold(1'b0, 40);
    chk("GAP.count", evq.size(), 5);
    chk_ev("GAP.E1",  0, f + CHAR_DLY, 8'h45, 1'b0);
    chk_ev("GAP.E2",  1, g + CHAR_DLY, 8'h45, 1'b0);
    chk_ev("GAP.sp1", 2, g + WORD_DLY, 8'h20, 1'b0);
    chk_ev("GAP.I",   3, h + CHAR_DLY, 8'h49, 1'b0);
    chk_ev("GAP.sp2", 4, h + WORD_DLY, 8'h20, 1'b0);

    // Reset during the gap after two dots discards the character
    evq.delete();
    hold(1'b1, U); hold(1'b0, U); hold(1'b1, U);
    hold(1'b0, 2);
    rst_i = 1'b1;
    hold(1'b0, 1);
    rst_i = 1'b0;
    chk("RST.busy", {31'h0, busy_o}, 32'h0);
    hold(1'b0, 40);
    chk("RST.silent", evq.size(), 0);
    hold(1'b1, U);
    f = cyc;
    hold(1'b0, 40);
    chk("RST.count", evq.size(), 2);
    chk_ev("RST.E",  0, f + CHAR_DLY, 8'h45, 1'b0);
    chk_ev("RST.sp", 1, f + WORD_DLY, 8'h20, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/morse_key_decoder.md
# morse_key_decoder

Sequential decoder that turns a single morse key input (on/off, e.g. a push button or UART-derived tone gate) into ASCII characters. Measures mark and space durations against a programmable dot-unit length, assembles dots/dashes into the team's 6-bit morse pattern format, and emits one ASCII byte per character plus a space per word gap. It is the receive-side counterpart of the ASCII-to-morse encoder and feeds the UART transmit path.

## Interface
- `CLKS_PER_UNIT`, default 1_000_000: clock cycles per morse dot unit (U); must be ≥ 2.
- `clk_i` input 1: system clock.
- `rst_i` input 1: synchronous, active-high reset.
- `key_i` input 1: raw key level, 1 = key down (mark); asynchronous, pre-debounced.
- `ascii_o` output 8: decoded character, valid only while `valid_o` is high.
- `valid_o` output 1: one-cycle pulse per decoded character or word space.
- `err_o` output 1: one-cycle pulse for an unknown pattern or more than 6 symbols.
- `busy_o` output 1: high while a character is pending (states MARK, SPACE, EMIT).

## Operation
- `key_i` passes through a 2-flop synchronizer (both flops reset to 0). `key_s` is the synchronized level.
- Pattern format: `pat[5:0]`, first symbol in bit 0, dot = 1, dash = 0; `len` is 0..6. Unused upper bits are 0.
- Counter `cnt`: width `$clog2(7*CLKS_PER_UNIT+1)`. Clears to 1 on every `key_s` edge, increments each cycle otherwise, saturates at 7U.
- States:
  - IDLE: no pending symbols. On `key_s` rising edge, go to MARK.
  - MARK: key down. On the falling edge, classify the mark: `cnt` < 2U is a dot, otherwise a dash. Write the symbol into `pat[len]` and increment `len`. If `len` was already 6, set `ovf` instead. Go to SPACE.
  - SPACE: key up with symbols pending. A rising edge before `cnt` reaches 2U returns to MARK (intra-character gap). When `cnt` reaches 2U, go to EMIT.
  - EMIT: one cycle. Look up `pat`/`len`.
    - Hit and not `ovf`: drive `ascii_o` and pulse `valid_o`.
    - Otherwise: pulse `err_o`, with `ascii_o` = 0x3F.
    - Clear `pat`, `len`, `ovf`. Go to WORD.
  - WORD: key up after a character. A rising edge goes to MARK. If `cnt` reaches 5U with no edge, pulse `valid_o` with `ascii_o` = 0x20 and go to IDLE. At most one space per gap.
- Lookup table (uppercase output only):
  - Letters A–Z, digits 0–9.
  - Punctuation `. , ? ' / ( ) : = + - " @`.
  - Encodings are the inverse of the encoder, e.g. A = len 2, pat 01; Y (-.--) = len 4, pat 0010; 0 = len 5, pat 00000; "." = len 6, pat 010101.
- A dash longer than 7U is still a dash; the saturated count has no further effect.

## Timing
- Reset values: `ascii_o` = 0, `valid_o` = 0, `err_o` = 0, `busy_o` = 0, state = IDLE, `cnt` = 0, `pat` = 0, `len` = 0, `ovf` = 0.
- Synchronizer latency: 2 cycles from `key_i` to `key_s`.
- Character output: `valid_o`/`err_o` are registered and assert in the cycle after EMIT, i.e. 2U + 1 cycles after the `key_s` falling edge of the last symbol.
- Word space: `valid_o` asserts 5U + 1 cycles after that falling edge, i.e. 3U cycles after the character pulse.
- `valid_o` and `err_o` are never high together. Outputs are not held; downstream must capture on the pulse (no backpressure).
- Reset mid-character: discards pending symbols and emits nothing. If the key is still held at reset release, a mark starts 2 cycles later.
- A press of exactly 2U cycles is a dash. A gap of exactly 2U cycles ends the character. A rising edge in the same cycle the gap count reaches its threshold is ignored for that cycle: the threshold wins and the edge is seen next cycle as a new mark.

## Structure
- Shared package `morse_pkg`:
  - pattern/length widths (6, 4)
  - threshold multipliers (DASH_UNITS = 2, CHAR_GAP_UNITS = 2, WORD_GAP_UNITS = 5)
  - ASCII_SPACE = 0x20, ASCII_QMARK = 0x3F
  - state encoding
- Sub-module `morse_code_to_ascii`: purely combinational, (`pat`, `len`) → (`ascii`, `hit`), instantiated once. The FSM, counter and synchronizer live in the top.

## Test plan
All scenarios use `CLKS_PER_UNIT` = 4 (U = 4).
- Reset: assert `rst_i` 3 cycles with `key_i` = 0 → all outputs 0, `busy_o` = 0.
- "A": key high 4, low 4, high 12, then low ≥ 30 → `ascii_o` = 0x41 with one `valid_o` pulse 9 cycles after the last fall; then 0x20 pulse 12 cycles later; no further pulses.
- "SOS" with 4-cycle symbol gaps and 12-cycle letter gaps → pulses 0x53, 0x4F, 0x53 and no space between them; one 0x20 after the final 20-cycle gap.
- Seven dots at 4-cycle spacing, then a 12-cycle gap → `err_o` pulse, `ascii_o` = 0x3F, `valid_o` stays low. Pattern len 6, pat 101010 (unknown) → `err_o`.
- Boundary: press exactly 8 cycles then release → decoded as "T" (0x54). Press 7 cycles → "E" (0x45).
- Reset mid-character: two dots entered, `rst_i` for 1 cycle during the gap → no `valid_o`/`err_o`; next "E" decodes as 0x45.
